diva: RTL and testbench

- Sequential unsigned restoring divider. It is the inverse of the biquad multiplier: it takes a product-width dividend and a coefficient-width divisor, and returns the quotient and remainder.
- Used by the coefficient-normalisation and gain-compensation path, where a scaled accumulator value must be divided back by a coefficient.
- Computes one quotient bit per clock and uses a start/busy/done handshake.

---
 rtl/biquad_pkg.sv | 24 ++
 rtl/diva_step.sv | 23 ++
 rtl/diva.sv | 99 +++++++++
 tb/tb_diva.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad datapath: default widths, derived-width
// helpers and the sequencing state type used by the multiplier and divider.
package biquad_pkg;

  localparam int DATAWIDTH_DEF = 12;
  localparam int COEFWIDTH_DEF = 16;

  // Product-width operand: sample times coefficient plus two guard bits.
  function automatic int nw_of(input int datawidth, input int coefwidth);
    return datawidth + coefwidth + 2;
  endfunction

  // Coefficient magnitude width (sign bit excluded).
  function automatic int dw_of(input int coefwidth);
    return coefwidth - 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/diva_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when the shifted partial remainder is large enough.
module diva_step #(
  parameter int DW = 15
) (
  input  logic [DW:0]   prem,
  input  logic          nbit,
  input  logic [DW-1:0] d,
  output logic [DW:0]   prem_next,
  output logic          qbit
);

  logic [DW+1:0] shifted;
  logic [DW:0]   trial;

  // The compare uses the full shifted width, so the subtraction only needs to
  // be exact when it is actually taken (result then fits in DW+1 bits).
  assign shifted   = {prem, nbit};
  assign trial     = shifted[DW:0] - {1'b0, d};
  assign qbit      = (shifted >= {2'b00, d});
  assign prem_next = qbit ? trial : shifted[DW:0];

endmodule

// File: rtl/diva.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a
// start/busy/done handshake; divide-by-zero completes immediately with div0.
module diva
  import biquad_pkg::*;
#(
  parameter  int DATAWIDTH = DATAWIDTH_DEF,
  parameter  int COEFWIDTH = COEFWIDTH_DEF,
  localparam int NW        = nw_of(DATAWIDTH, COEFWIDTH),
  localparam int DW        = dw_of(COEFWIDTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] q,
  output logic [DW-1:0] r,
  output logic          div0
);

  localparam int CW = $clog2(NW);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [NW-1:0] n_shift;
  logic [DW-1:0] d_reg;
  logic [DW:0]   prem;
  logic [DW:0]   prem_next;
  logic          qbit;
  logic          accept;

  diva_step #(.DW(DW)) u_step (
    .prem      (prem),
    .nbit      (n_shift[NW-1]),
    .d         (d_reg),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start && (state != RUN);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (d == '0) ? DONE : RUN;
      RUN:     if (cnt == '0) state_next = DONE;
      DONE:    if (start) state_next = (d == '0) ? DONE : RUN;
               else       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: these are plain registers, not a memory array, so all of them are
  // cleared by the asynchronous reset, including the result outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt     <= '0;
      n_shift <= '0;
      d_reg   <= '0;
      prem    <= '0;
      q       <= '0;
      r       <= '0;
      div0    <= 1'b0;
    end else if (accept) begin
      cnt     <= CW'(NW - 1);
      n_shift <= n;
      d_reg   <= d;
      prem    <= '0;
      div0    <= (d == '0);
      // A zero divisor has no iterations, so its result is published now.
      if (d == '0) begin
        q <= '1;
        r <= n[DW-1:0];
      end
    end else if (state == RUN) begin
      n_shift <= {n_shift[NW-2:0], qbit};
      prem    <= prem_next;
      cnt     <= cnt - CW'(1);
      if (cnt == '0) begin
        q <= {n_shift[NW-2:0], qbit};
        r <= prem_next[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_diva.sv
// Scoreboard bench for diva: an accept tracker pushes reference results
// computed with plain integer division; a monitor pops and compares on done.
module tb_diva;
  import biquad_pkg::*;

  localparam int NW = 30;
  localparam int DW = 15;
  localparam logic [NW-1:0] NMASK = '1;

  logic          clk = 1'b0;
  logic          nreset;
  logic          start;
  logic [NW-1:0] n;
  logic [DW-1:0] d;
  logic          busy, done, div0;
  logic [NW-1:0] q;
  logic [DW-1:0] r;

  always #5 clk = ~clk;

  diva dut (
    .clk    (clk),
    .nreset (nreset),
    .start  (start),
    .n      (n),
    .d      (d),
    .busy   (busy),
    .done   (done),
    .q      (q),
    .r      (r),
    .div0   (div0)
  );

  typedef struct {
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          div0;
    int            acc_edge;
    int            busy_exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors      = 0;
  int   checks      = 0;
  int   cyc         = 0;
  int   free_edge   = 0;
  int   busy_cnt    = 0;
  int   n_accepts   = 0;
  int   acc_in_done = 0;
  int   done_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference result from the arithmetic definition of unsigned division.
  function automatic exp_t model(input logic [NW-1:0] nn, input logic [DW-1:0] dd, input int edge_i);
    exp_t m;
    longint unsigned ln, ld;
    ln = longint'(nn);
    ld = longint'(dd);
    if (ld == 0) begin
      m.q        = '1;
      m.r        = nn[DW-1:0];
      m.div0     = 1'b1;
      m.busy_exp = 0;
    end else begin
      m.q        = NW'(ln / ld);
      m.r        = DW'(ln % ld);
      m.div0     = 1'b0;
      m.busy_exp = NW;
    end
    m.acc_edge = edge_i;
    return m;
  endfunction

  // Accept tracker: an operation occupies the divider for NW steps plus its
  // done cycle, during which a new request may already be taken.
  always @(posedge clk) begin
    cyc++;
    if (nreset && start && cyc >= free_edge) begin
      sb.push_back(model(n, d, cyc));
      free_edge = cyc + ((d == '0) ? 1 : NW + 1);
      n_accepts++;
      if (done) acc_in_done++;
    end
  end

  // Monitor: latency counts the cycle in which start was presented as cycle 1.
  always @(negedge clk) begin
    if (nreset) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("q", q, e.q);
          check("r", r, e.r);
          check("div0", div0, e.div0);
          check("latency", cyc - e.acc_edge + 1, e.div0 ? 1 : NW + 1);
          check("busy_cycles", busy_cnt, e.busy_exp);
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic wait_free();
    int k = 0;
    while ((sb.size() != 0 || cyc + 1 < free_edge) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("wait_free_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [NW-1:0] nn, input logic [DW-1:0] dd);
    wait_free();
    start = 1'b1;
    n     = nn;
    d     = dd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_accepts(input int target);
    int k = 0;
    while (n_accepts < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("accept_timeout", n_accepts, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_q"}, q, 0);
    check({tag, "_r"}, r, 0);
    check({tag, "_div0"}, div0, 0);
  endtask

  initial begin
    int base, in_done0, done0;
    logic [NW-1:0] rn;
    logic [DW-1:0] rd;
    int sel;

    nreset = 1'b0;
    start  = 1'b0;
    n      = '0;
    d      = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Directed cases, including extremes and divide-by-zero.
    do_op(30'd8369910, 15'd678);
    check("busy_after_accept", busy, 1);
    do_op(30'd1000, 15'd7);
    do_op(30'd5, 15'd9);
    do_op(NMASK, 15'd1);
    do_op(NMASK, 15'h7FFF);
    do_op(30'h12345, 15'd0);
    do_op(30'd10, 15'd3);

    // A start pulse with new operands mid-run must be ignored.
    do_op(30'd1000, 15'd7);
    repeat (5) @(negedge clk);
    start = 1'b1;
    n     = 30'd99;
    d     = 15'd2;
    @(negedge clk);
    start = 1'b0;

    // start held high across three operations, one of them divide-by-zero.
    wait_free();
    base     = n_accepts;
    in_done0 = acc_in_done;
    start    = 1'b1;
    n        = 30'd777777;
    d        = 15'd13;
    wait_accepts(base + 1);
    n = 30'd123;
    d = 15'd0;
    wait_accepts(base + 2);
    n = 30'h2000_0000;
    d = 15'h7FFF;
    wait_accepts(base + 3);
    start = 1'b0;
    wait_free();
    check("held_start_accepts_in_done", acc_in_done - in_done0, 2);

    // Reset in the middle of a run aborts it without a done pulse.
    do_op(30'd123456789, 15'd321);
    repeat (10) @(negedge clk);
    nreset = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    sb.delete();
    free_edge = 0;
    busy_cnt  = 0;
    done0     = done_cnt;
    @(negedge clk);
    nreset = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", done_cnt - done0, 0);
    do_op(30'd55555, 15'd44);

    // Randomized operands with occasional zero and small divisors.
    for (int i = 0; i < 25; i++) begin
      rn  = NW'($urandom) & NMASK;
      sel = $urandom_range(0, 9);
      if (sel == 0)      rd = '0;
      else if (sel <= 2) rd = DW'($urandom_range(1, 15));
      else               rd = DW'($urandom_range(1, 32767));
      do_op(rn, rd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_free();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
